key_debounce_array: RTL and testbench

- Parametrised N-channel key debouncer for mechanical push-buttons; sits between raw key pins and the user-interface control logic.
- Each channel has its own input synchroniser and state machine; all channels share one 1 ms tick prescaler.
- Outputs per key:
  - debounced level
  - one-cycle press pulse
  - one-cycle release pulse
  - long-press pulse, with optional auto-repeat while the key is held

---
 rtl/key_debounce_array_if.sv | 26 ++
 rtl/key_debounce_array.sv | 160 ++++++++++++++++
 tb/tb_key_debounce_array.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_array_if.sv
// rtl/key_debounce_array_if.sv - key pin and debounced event bundle for key_debounce_array
interface key_debounce_array_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] Key_In;
  logic [N_KEYS-1:0] Key_Level;
  logic [N_KEYS-1:0] Press_Pulse;
  logic [N_KEYS-1:0] Release_Pulse;
  logic [N_KEYS-1:0] Long_Pulse;

  modport master (
    output Key_In,
    input  Key_Level,
    input  Press_Pulse,
    input  Release_Pulse,
    input  Long_Pulse
  );

  modport slave (
    input  Key_In,
    output Key_Level,
    output Press_Pulse,
    output Release_Pulse,
    output Long_Pulse
  );
endinterface

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - N-channel key debouncer with press/release/long-press pulses
// All channels share one 1 ms tick; each channel has its own synchroniser and FSM.
module key_debounce_array #(
  parameter int          N_KEYS    = 4,
  parameter logic [15:0] T1MS      = 16'd49_999,
  parameter int          DB_MS     = 10,
  parameter int          LONG_MS   = 1000,
  parameter int          REPEAT_MS = 0
) (
  input  logic CLK,
  input  logic RST_N,
  key_debounce_array_if.slave kif
);

  typedef enum logic [1:0] {IDLE, WAIT_DN, DOWN, WAIT_UP} state_t;

  localparam logic [7:0]  DB_LAST  = 8'(DB_MS - 1);
  localparam logic [15:0] LONG_W   = 16'(LONG_MS);
  localparam logic [15:0] REP_LAST = (REPEAT_MS == 0) ? 16'd0 : 16'(REPEAT_MS - 1);
  localparam bit          LONG_EN  = (LONG_MS != 0);
  localparam bit          REP_EN   = (REPEAT_MS != 0);

  logic [15:0]       pre_q;
  logic              tick;
  logic [N_KEYS-1:0] sync1, sync2;
  logic [N_KEYS-1:0] lvl_vec, press_vec, rel_vec, long_vec;

  assign tick = (pre_q == T1MS);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q <= '0;
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      pre_q <= tick ? '0 : pre_q + 16'd1;
      sync1 <= kif.Key_In;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    state_t      state_q, state_d;
    logic [7:0]  db_q, db_d;
    logic [15:0] hold_q, hold_d, rep_q, rep_d, hold_inc;
    logic        lvl_q, lvl_d, press_q, press_d, rel_q, rel_d, long_q, long_d;
    logic        p;

    assign p        = ~sync2[k];
    assign hold_inc = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= IDLE;
        db_q    <= '0;
        hold_q  <= '0;
        rep_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        db_q    <= db_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    always_comb begin
      state_d = state_q;
      db_d    = db_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (p) begin
            state_d = WAIT_DN;
            db_d    = '0;
          end
        end
        WAIT_DN: begin
          if (!p) begin
            state_d = IDLE;
            db_d    = '0;
          end else if (tick) begin
            if (db_q == DB_LAST) begin
              state_d = DOWN;
              db_d    = '0;
              hold_d  = '0;
              lvl_d   = 1'b1;
              press_d = 1'b1;
            end else begin
              db_d = db_q + 8'd1;
            end
          end
        end
        DOWN: begin
          if (!p) begin
            state_d = WAIT_UP;
            db_d    = '0;
          end else if (tick) begin
            hold_d = hold_inc;
            // The saturation guard stops LONG_MS=65535 from re-firing once hold_cnt is pinned.
            if (LONG_EN && hold_q != 16'hFFFF && hold_inc == LONG_W) begin
              long_d = 1'b1;
              rep_d  = '0;
            end else if (LONG_EN && REP_EN && hold_q >= LONG_W) begin
              if (rep_q == REP_LAST) begin
                long_d = 1'b1;
                rep_d  = '0;
              end else begin
                rep_d = rep_q + 16'd1;
              end
            end
          end
        end
        WAIT_UP: begin
          // Returning to DOWN keeps hold_cnt so the long-press timeline resumes.
          if (p) begin
            state_d = DOWN;
            db_d    = '0;
          end else if (tick) begin
            if (db_q == DB_LAST) begin
              state_d = IDLE;
              db_d    = '0;
              lvl_d   = 1'b0;
              rel_d   = 1'b1;
            end else begin
              db_d = db_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          db_d    = '0;
        end
      endcase
    end

    assign lvl_vec[k]   = lvl_q;
    assign press_vec[k] = press_q;
    assign rel_vec[k]   = rel_q;
    assign long_vec[k]  = long_q;
  end

  assign kif.Key_Level     = lvl_vec;
  assign kif.Press_Pulse   = press_vec;
  assign kif.Release_Pulse = rel_vec;
  assign kif.Long_Pulse    = long_vec;

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - self-checking bench for key_debounce_array
module tb_key_debounce_array;
  localparam int          N         = 4;
  localparam logic [15:0] T1MS      = 16'd9;
  localparam int          PER       = 10;
  localparam int          DB_MS     = 3;
  localparam int          LONG_MS   = 8;
  localparam int          REPEAT_MS = 2;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  key_debounce_array_if #(.N_KEYS(N)) kif ();

  key_debounce_array #(
    .N_KEYS(N), .T1MS(T1MS), .DB_MS(DB_MS), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .kif  (kif)
  );

  // Reference: a level flips once DB_MS ticks are seen while the synchronised key keeps
  // disagreeing with it (the first disagreeing edge is only noticed, not counted); hold
  // ticks accrue while pressed and agreeing for two edges in a row.
  int           m_edge;
  logic [N-1:0] m_s1, m_s2, m_prev, m_lvl, m_press, m_rel, m_long;
  int           m_wait[N];
  int           m_hold[N];

  always @(posedge CLK or negedge RST_N) begin : model
    logic [N-1:0] p;
    logic         tk;
    if (!RST_N) begin
      m_edge = 0; m_s1 = '1; m_s2 = '1; m_prev = '0; m_lvl = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < N; k++) begin m_wait[k] = 0; m_hold[k] = 0; end
    end else begin
      tk = (m_edge % PER) == PER - 1;
      m_edge++;
      p = ~m_s2;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int k = 0; k < N; k++) begin
        if (m_lvl[k] && p[k] && m_prev[k] && tk) begin
          m_hold[k]++;
          if (m_hold[k] == LONG_MS || (m_hold[k] > LONG_MS && (m_hold[k] - LONG_MS) % REPEAT_MS == 0))
            m_long[k] = 1'b1;
        end
        if (p[k] == m_lvl[k]) begin
          m_wait[k] = 0;
        end else if (m_prev[k] != m_lvl[k] && tk) begin
          m_wait[k]++;
          if (m_wait[k] == DB_MS) begin
            m_wait[k] = 0;
            m_hold[k] = 0;
            m_lvl[k]  = p[k];
            if (p[k]) m_press[k] = 1'b1;
            else      m_rel[k]   = 1'b1;
          end
        end
      end
      m_prev = p;
      m_s2   = m_s1;
      m_s1   = kif.Key_In;
    end
  end

  logic [4*N-1:0] obs_v, exp_v;
  assign obs_v = {kif.Key_Level, kif.Press_Pulse, kif.Release_Pulse, kif.Long_Pulse};
  assign exp_v = {m_lvl, m_press, m_rel, m_long};

  task automatic test_reset;
    kif.Key_In = '1;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (obs_v !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs_v); end
    RST_N = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL reset_idle t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
    end
  endtask

  task automatic test_clean_press;
    int pc, pat;
    pc = 0; pat = -1;
    kif.Key_In[0] = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL clean_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if (kif.Press_Pulse[0]) begin pc++; if (pat < 0) pat = c; end
      checks++;
      if (kif.Key_Level[3:1] !== 3'b000) begin failures++; $display("FAIL clean_others got=%b exp=000", kif.Key_Level[3:1]); end
    end
    checks++;
    if (pc != 1) begin failures++; $display("FAIL clean_press_count got=%0d exp=1", pc); end
    checks++;
    if (pat < 23 || pat > 33) begin failures++; $display("FAIL clean_latency got=%0d exp=23..33", pat); end
    checks++;
    if (kif.Key_Level[0] !== 1'b1) begin failures++; $display("FAIL clean_level got=%b exp=1", kif.Key_Level[0]); end
    kif.Key_In[0] = 1'b1;
    repeat (60) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL clean_release_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
    end
    checks++;
    if (kif.Key_Level[0] !== 1'b0) begin failures++; $display("FAIL clean_released got=%b exp=0", kif.Key_Level[0]); end
  endtask

  task automatic test_bounce;
    int pc, rc, pat;
    pc = 0; rc = 0; pat = -1;
    for (int c = 0; c < 120; c++) begin
      kif.Key_In[1] = (c < 40) ? logic'((c / 4) % 2) : 1'b0;
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL bounce_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if (kif.Press_Pulse[1]) begin pc++; if (pat < 0) pat = c - 40; end
      if (kif.Release_Pulse[1]) rc++;
    end
    checks++;
    if (pc != 1) begin failures++; $display("FAIL bounce_press_count got=%0d exp=1", pc); end
    checks++;
    if (pat < 0 || pat > 33) begin failures++; $display("FAIL bounce_latency got=%0d exp=0..33", pat); end
    checks++;
    if (rc != 0) begin failures++; $display("FAIL bounce_release_count got=%0d exp=0", rc); end
    kif.Key_In[1] = 1'b1;
    repeat (60) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL bounce_release_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
    end
  endtask

  task automatic test_glitch;
    int ev;
    ev = 0;
    for (int c = 0; c < 65; c++) begin
      kif.Key_In[2] = (c < 15) ? 1'b0 : 1'b1;
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL glitch_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if (kif.Key_Level[2] || kif.Press_Pulse[2] || kif.Release_Pulse[2] || kif.Long_Pulse[2]) ev++;
    end
    checks++;
    if (ev != 0) begin failures++; $display("FAIL glitch_events got=%0d exp=0", ev); end
  endtask

  task automatic test_long_repeat;
    int pp, rp, pc, rc, late, exp_n, prev_l;
    int lq[$];
    pp = -1; rp = -1; pc = 0; rc = 0; late = 0;
    kif.Key_In[3] = 1'b0;
    for (int c = 1; c <= 280; c++) begin
      if (c == 201) kif.Key_In[3] = 1'b1;
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL long_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if (kif.Press_Pulse[3]) begin pc++; pp = c; end
      if (kif.Release_Pulse[3]) begin rc++; rp = c; end
      if (kif.Long_Pulse[3]) begin
        lq.push_back(c);
        if (rp >= 0) late++;
      end
    end
    checks++;
    if (pc != 1) begin failures++; $display("FAIL long_press_count got=%0d exp=1", pc); end
    checks++;
    if (rc != 1) begin failures++; $display("FAIL long_release_count got=%0d exp=1", rc); end
    exp_n = (pp < 0) ? 0 : (202 - (pp + LONG_MS * PER)) / (REPEAT_MS * PER) + 1;
    checks++;
    if (lq.size() != exp_n) begin failures++; $display("FAIL long_count got=%0d exp=%0d", lq.size(), exp_n); end
    checks++;
    if (lq.size() == 0 || lq[0] != pp + LONG_MS * PER) begin
      failures++; $display("FAIL long_first got=%0d exp=%0d", (lq.size() == 0) ? -1 : lq[0], pp + LONG_MS * PER);
    end
    prev_l = (lq.size() == 0) ? 0 : lq[0];
    for (int i = 1; i < lq.size(); i++) begin
      checks++;
      if (lq[i] - prev_l != REPEAT_MS * PER) begin
        failures++; $display("FAIL long_repeat_gap got=%0d exp=%0d", lq[i] - prev_l, REPEAT_MS * PER);
      end
      prev_l = lq[i];
    end
    checks++;
    if (late != 0) begin failures++; $display("FAIL long_after_release got=%0d exp=0", late); end
  endtask

  task automatic test_simultaneous;
    int full, part;
    full = 0; part = 0;
    kif.Key_In = 4'b0000;
    repeat (60) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL simul_press_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if (kif.Press_Pulse == 4'b1111) full++;
      else if (kif.Press_Pulse != 4'b0000) part++;
    end
    checks++;
    if (full != 1 || part != 0) begin failures++; $display("FAIL simul_press full=%0d part=%0d exp=1,0", full, part); end
    full = 0; part = 0;
    kif.Key_In = 4'b1111;
    repeat (60) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL simul_release_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if (kif.Release_Pulse == 4'b1111) full++;
      else if (kif.Release_Pulse != 4'b0000) part++;
    end
    checks++;
    if (full != 1 || part != 0) begin failures++; $display("FAIL simul_release full=%0d part=%0d exp=1,0", full, part); end
  endtask

  task automatic test_reset_mid;
    int pat;
    pat = -1;
    kif.Key_In[0] = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rstmid_pre_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (obs_v !== '0) begin failures++; $display("FAIL rstmid_outputs got=%h exp=0", obs_v); end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if (kif.Press_Pulse[0] && pat < 0) pat = c;
    end
    checks++;
    if (pat != DB_MS * PER) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", pat, DB_MS * PER); end
    kif.Key_In[0] = 1'b1;
    repeat (60) @(negedge CLK);
  endtask

  task automatic test_random;
    int rem[N];
    int overlap;
    overlap = 0;
    for (int k = 0; k < N; k++) rem[k] = $urandom_range(1, 60);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        rem[k]--;
        if (rem[k] <= 0) begin
          kif.Key_In[k] = ~kif.Key_In[k];
          rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 200) : $urandom_range(1, 30);
        end
      end
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL random_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
      if ((kif.Long_Pulse & (kif.Press_Pulse | kif.Release_Pulse)) != '0) overlap++;
    end
    checks++;
    if (overlap != 0) begin failures++; $display("FAIL random_long_overlap got=%0d exp=0", overlap); end
    kif.Key_In = '1;
    repeat (100) begin
      @(negedge CLK);
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL random_settle_model t=%0t got=%h exp=%h", $time, obs_v, exp_v); end
    end
  endtask

  initial begin
    kif.Key_In = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
